logic_gates_pipe: RTL and testbench

LOGIC_GATES_PIPE -- requirements
Module: logic_gates_pipe

---
 rtl/logic_gates_pipe.sv | 145 ++++++++++++++
 tb/tb_logic_gates_pipe.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_gates_pipe.sv
// logic_gates_pipe: two-stage valid/ready pipeline that applies a bitwise gate to A and B.
// Defining LG_PARITY_EN adds the registered even-parity output PAR.
module logic_gates_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OP,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] Y,
  output logic [2:0]       OP_OUT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [CNT_W-1:0] TX_COUNT
`ifdef LG_PARITY_EN
  ,
  output logic             PAR
`endif
);

  function automatic logic [WIDTH-1:0] gate_eval(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [2:0]       op);
    logic [WIDTH-1:0] r;
    case (op)
      3'b000:  r = a & b;
      3'b001:  r = ~(a & b);
      3'b010:  r = a | b;
      3'b011:  r = ~(a | b);
      3'b100:  r = ~a;
      3'b101:  r = a ^ b;
      3'b110:  r = ~(a ^ b);
      3'b111:  r = b;
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;
  logic [2:0]       s1_op_r;
  logic             s2_valid_r;
  logic [WIDTH-1:0] y_r;
  logic [2:0]       op_out_r;
  logic [CNT_W-1:0] tx_count_r;
  logic             in_ready_s;
  logic             in_xfer_s;
  logic             s1_adv_s;
  logic             out_xfer_s;
  logic [WIDTH-1:0] y_next_s;

  // Handshake decode; IN_READY deliberately ignores IN_VALID
  always_comb begin
    in_ready_s = 1'b0;
    in_xfer_s  = 1'b0;
    s1_adv_s   = 1'b0;
    out_xfer_s = 1'b0;
    y_next_s   = {WIDTH{1'b0}};
    in_ready_s = !s1_valid_r || !s2_valid_r || OUT_READY;
    in_xfer_s  = IN_VALID && in_ready_s;
    s1_adv_s   = s1_valid_r && (!s2_valid_r || OUT_READY);
    out_xfer_s = s2_valid_r && OUT_READY;
    y_next_s   = gate_eval(s1_a_r, s1_b_r, s1_op_r);
  end

  // Stage 1: operand capture
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= {WIDTH{1'b0}};
      s1_b_r     <= {WIDTH{1'b0}};
      s1_op_r    <= 3'b000;
    end else if (in_xfer_s) begin
      s1_valid_r <= 1'b1;
      s1_a_r     <= A;
      s1_b_r     <= B;
      s1_op_r    <= OP;
    end else if (s1_adv_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage 2: result register, held while the consumer stalls
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s2_valid_r <= 1'b0;
      y_r        <= {WIDTH{1'b0}};
      op_out_r   <= 3'b000;
    end else if (s1_adv_s) begin
      s2_valid_r <= 1'b1;
      y_r        <= y_next_s;
      op_out_r   <= s1_op_r;
    end else if (out_xfer_s) begin
      s2_valid_r <= 1'b0;
    end else begin
      s2_valid_r <= s2_valid_r;
    end
  end

  // Completed output transfers, wrapping naturally at 2^CNT_W
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tx_count_r <= {CNT_W{1'b0}};
    end else if (out_xfer_s) begin
      tx_count_r <= tx_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      tx_count_r <= tx_count_r;
    end
  end

`ifdef LG_PARITY_EN
  logic par_r;

  // Parity loads together with Y so both stay coherent under stall
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      par_r <= 1'b0;
    end else if (s1_adv_s) begin
      par_r <= even_parity(y_next_s);
    end else begin
      par_r <= par_r;
    end
  end

  assign PAR = par_r;
`endif

  assign IN_READY  = in_ready_s;
  assign Y         = y_r;
  assign OP_OUT    = op_out_r;
  assign OUT_VALID = s2_valid_r;
  assign TX_COUNT  = tx_count_r;

endmodule

// File: tb/tb_logic_gates_pipe.sv
// Self-checking bench for logic_gates_pipe: truth table, backpressure, streaming,
// counter wrap (second instance with CNT_W=4), reset mid-operation and random traffic.
module tb_logic_gates_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a, b;
  logic [2:0] op;
  logic       in_valid, out_ready;
  logic       in_ready, out_valid, in_ready4, out_valid4;
  logic [7:0] y, y4;
  logic [2:0] op_out, op_out4;
  logic [15:0] tx_count;
  logic [3:0]  tx_count4;
  logic        par, par4;

  always #5 clk = ~clk;

  logic_gates_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .CLK(clk), .RST_N(rst_n), .A(a), .B(b), .OP(op), .IN_VALID(in_valid),
    .IN_READY(in_ready), .Y(y), .OP_OUT(op_out), .OUT_VALID(out_valid),
    .OUT_READY(out_ready), .TX_COUNT(tx_count)
`ifdef LG_PARITY_EN
    , .PAR(par)
`endif
  );

  logic_gates_pipe #(.WIDTH(8), .CNT_W(4)) dut4 (
    .CLK(clk), .RST_N(rst_n), .A(a), .B(b), .OP(op), .IN_VALID(in_valid),
    .IN_READY(in_ready4), .Y(y4), .OP_OUT(op_out4), .OUT_VALID(out_valid4),
    .OUT_READY(out_ready), .TX_COUNT(tx_count4)
`ifdef LG_PARITY_EN
    , .PAR(par4)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] y;
  } vec_t;

  typedef struct {
    logic [7:0] y;
    logic [2:0] op;
    int         age;
  } item_t;

  vec_t  tbl[8];
  item_t q[$];
  int    tx_cnt;
  int    n_vec = 0;
  int    n_err = 0;

  function automatic logic [7:0] ref_gate(input logic [7:0] ra, input logic [7:0] rb,
                                          input logic [2:0] rop);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      case (rop)
        3'd0: r[i] = ra[i] && rb[i];
        3'd1: r[i] = !(ra[i] && rb[i]);
        3'd2: r[i] = ra[i] || rb[i];
        3'd3: r[i] = !(ra[i] || rb[i]);
        3'd4: r[i] = !ra[i];
        3'd5: r[i] = ra[i] != rb[i];
        3'd6: r[i] = ra[i] == rb[i];
        default: r[i] = rb[i];
      endcase
    end
    return r;
  endfunction

  // The oldest item is presentable once it has lived through one clock edge.
  function automatic bit m_out_valid();
    return (q.size() > 0) && (q[0].age >= 1);
  endfunction

  function automatic bit m_in_ready();
    return (q.size() < 2) || (m_out_valid() && out_ready);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [15:0] e16;
    logic [3:0]  e4;
    int          ones;
    e16 = tx_cnt[15:0];
    e4  = tx_cnt[3:0];
    chk("out_valid", out_valid, m_out_valid());
    chk("out_valid4", out_valid4, m_out_valid());
    if (m_out_valid()) begin
      chk("y", y, q[0].y);
      chk("op_out", op_out, q[0].op);
      chk("y4", y4, q[0].y);
`ifdef LG_PARITY_EN
      ones = 0;
      for (int i = 0; i < 8; i++) ones += q[0].y[i];
      chk("par", par, ones % 2);
`endif
    end
    chk("tx_count", tx_count, e16);
    chk("tx_count4", tx_count4, e4);
  endtask

  // One clock: apply inputs at the falling edge, check, step model, check again.
  task automatic cycle(input bit v, input logic [7:0] ia, input logic [7:0] ib,
                       input logic [2:0] iop, input bit ordy);
    bit ix, ox;
    in_valid = v; a = ia; b = ib; op = iop; out_ready = ordy;
    #1;
    chk("in_ready", in_ready, m_in_ready());
    ix = v && m_in_ready();
    ox = m_out_valid() && ordy;
    @(posedge clk);
    if (ox) begin
      void'(q.pop_front());
      tx_cnt++;
    end
    foreach (q[i]) q[i].age++;
    if (ix) q.push_back('{ref_gate(ia, ib, iop), iop, 0});
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_y", y, 8'h00);
    chk("rst_op_out", op_out, 3'b000);
    chk("rst_tx_count", tx_count, 16'h0000);
    chk("rst_tx_count4", tx_count4, 4'h0);
    chk("rst_in_ready", in_ready, 1'b1);
`ifdef LG_PARITY_EN
    chk("rst_par", par, 1'b0);
`endif
    q.delete();
    tx_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready_hold", in_ready, 1'b1);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; a = 8'h00; b = 8'h00; op = 3'b000; in_valid = 1'b0; out_ready = 1'b0;
    tx_cnt = 0;
    tbl[0] = '{8'hF0, 8'hCC, 3'd0, 8'hC0};
    tbl[1] = '{8'hF0, 8'hCC, 3'd1, 8'h3F};
    tbl[2] = '{8'hF0, 8'hCC, 3'd2, 8'hFC};
    tbl[3] = '{8'hF0, 8'hCC, 3'd3, 8'h03};
    tbl[4] = '{8'hF0, 8'hCC, 3'd4, 8'h0F};
    tbl[5] = '{8'hF0, 8'hCC, 3'd5, 8'h3C};
    tbl[6] = '{8'hF0, 8'hCC, 3'd6, 8'hC3};
    tbl[7] = '{8'hF0, 8'hCC, 3'd7, 8'hCC};
    @(negedge clk);
    do_reset();

    // Truth table, streamed: entry i appears after the following cycle
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) cycle(1'b1, tbl[i].a, tbl[i].b, tbl[i].op, 1'b1);
      else       cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
      if (i >= 1) begin
        chk("tt_valid", out_valid, 1'b1);
        chk("tt_y", y, tbl[i-1].y);
        chk("tt_op", op_out, tbl[i-1].op);
      end
    end
    cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

    // Backpressure: two buffered, third refused until the consumer resumes
    do_reset();
    cycle(1'b1, 8'h11, 8'h22, 3'd2, 1'b0);
    chk("bp_rdy1", in_ready, 1'b1);
    cycle(1'b1, 8'h5A, 8'h0F, 3'd5, 1'b0);
    chk("bp_full", in_ready, 1'b0);
    cycle(1'b1, 8'hF0, 8'h0F, 3'd1, 1'b0);
    chk("bp_hold_y", y, 8'h33);
    chk("bp_hold_rdy", in_ready, 1'b0);
    cycle(1'b1, 8'hF0, 8'h0F, 3'd1, 1'b1);
    chk("bp_y2", y, 8'h55);
    cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    chk("bp_y3", y, 8'hFF);
    cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    chk("bp_count", tx_count, 16'd3);

    // Streaming 16 then one more for the 4-bit counter wrap
    do_reset();
    for (int i = 0; i < 18; i++) begin
      cycle(i < 16, 8'($urandom), 8'($urandom), 3'($urandom), 1'b1);
      if (i >= 1 && i <= 16) chk("stream_ov", out_valid, 1'b1);
    end
    chk("stream_count", tx_count, 16'd16);
    chk("stream_count4", tx_count4, 4'd0);
    cycle(1'b1, 8'h01, 8'h02, 3'd2, 1'b1);
    cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    chk("wrap_count4", tx_count4, 4'd1);
    chk("wrap_count", tx_count, 16'd17);

`ifdef LG_PARITY_EN
    cycle(1'b1, 8'h00, 8'h07, 3'd7, 1'b1);
    cycle(1'b1, 8'h00, 8'h03, 3'd7, 1'b1);
    chk("par_07", par, 1'b1);
    cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    chk("par_03", par, 1'b0);
`endif

    // Reset with both stages full; nothing may reappear afterwards
    cycle(1'b1, 8'hAA, 8'h55, 3'd2, 1'b0);
    cycle(1'b1, 8'h0F, 8'hF0, 3'd5, 1'b0);
    chk("mid_full", in_ready, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
      chk("no_stale", out_valid, 1'b0);
    end

    // Random traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) < 7, 8'($urandom), 8'($urandom), 3'($urandom),
            $urandom_range(0, 9) < 6);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
